// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul sequencer and its skew feeder.
package matmul_pkg;

  localparam int MM_DATA_WIDTH = 16;
  localparam int MM_MAX_DIM    = 4;
  localparam int DIM_W         = $clog2(MM_MAX_DIM);
  localparam int STEP_W        = $clog2(3*MM_MAX_DIM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  // Element [r][c] of a flat operand bus in the default configuration.
  function automatic logic [MM_DATA_WIDTH-1:0] elem(
    input logic [MM_MAX_DIM*MM_MAX_DIM*MM_DATA_WIDTH-1:0] flat,
    input int r,
    input int c
  );
    return flat[((r*MM_MAX_DIM)+c)*MM_DATA_WIDTH +: MM_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/matmul_skew_feeder.sv
// Combinational skewed lane selection for one array edge; TRANSPOSE picks
// columns (B, top edge) instead of rows (A, left edge).
module matmul_skew_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int MAX_DIM    = MM_MAX_DIM,
  parameter bit TRANSPOSE  = 1'b0,
  localparam int DW        = $clog2(MAX_DIM),
  localparam int SW        = $clog2(3*MAX_DIM)
) (
  input  logic                                  active_i,
  input  logic [SW-1:0]                         t_i,
  input  logic [DW-1:0]                         lanes_i,
  input  logic [DW-1:0]                         k_i,
  input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] flat_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0]         feed_o
);

  for (genvar g = 0; g < MAX_DIM; g++) begin : g_lane
    localparam int L = g;
    int d;
    int idx;

    // Skew offset kept signed so lanes ahead of the wavefront read as zero.
    always_comb begin
      d   = int'(t_i) - L;
      idx = TRANSPOSE ? (d*MAX_DIM + L) : (L*MAX_DIM + d);
      feed_o[L*DATA_WIDTH +: DATA_WIDTH] = '0;
      if (active_i && (L <= int'(lanes_i)) && (d >= 0) && (d <= int'(k_i)))
        feed_o[L*DATA_WIDTH +: DATA_WIDTH] = flat_i[idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Control sequencer for the output-stationary systolic array: clear, skewed
// feed, drain, scratchpad write handshake, completion pulse.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = MM_DATA_WIDTH,
  parameter int MAX_DIM    = MM_MAX_DIM,
  parameter int PE_LAT     = 1,
  localparam int DW        = $clog2(MAX_DIM),
  localparam int SW        = $clog2(3*MAX_DIM),
  localparam int FW        = MAX_DIM*DATA_WIDTH,
  localparam int MW        = MAX_DIM*MAX_DIM*DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [DW-1:0] dim_n_i,
  input  logic [DW-1:0] dim_k_i,
  input  logic [DW-1:0] dim_m_i,
  input  logic [MW-1:0] mat_a_i,
  input  logic [MW-1:0] mat_b_i,
  output logic [FW-1:0] a_feed_o,
  output logic [FW-1:0] b_feed_o,
  output logic          pe_clear_o,
  output logic          pe_valid_o,
  output logic          sp_wr_o,
  input  logic          sp_ack_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int LW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  state_e        state_q, state_d;
  logic [SW-1:0] t_q, t_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [DW-1:0] n_q, n_d, k_q, k_d, m_q, m_d;
  logic [FW-1:0] a_feed_q, b_feed_q, a_feed_d, b_feed_d;
  logic [SW-1:0] t_last;

  // Dims are stored minus one, so their sum is directly T-1.
  assign t_last = SW'(n_q) + SW'(k_q) + SW'(m_q);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    lat_d   = lat_q;
    n_d     = n_q;
    k_d     = k_q;
    m_d     = m_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          n_d     = dim_n_i;
          k_d     = dim_k_i;
          m_d     = dim_m_i;
          t_d     = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (t_q == t_last) begin
          t_d     = '0;
          lat_d   = '0;
          state_d = S_DRAIN;
        end else begin
          t_d = t_q + SW'(1);
        end
      end
      S_DRAIN: begin
        if (lat_q == LW'(PE_LAT-1)) state_d = S_WRITE;
        else                        lat_d   = lat_q + LW'(1);
      end
      S_WRITE: begin
        if (sp_ack_i) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Feeds are computed for the upcoming step and registered, so the operand
  // buses never reach the outputs combinationally.
  matmul_skew_feeder #(
    .DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .TRANSPOSE(1'b0)
  ) u_feed_a (
    .active_i(state_d == S_FEED),
    .t_i     (t_d),
    .lanes_i (n_d),
    .k_i     (k_d),
    .flat_i  (mat_a_i),
    .feed_o  (a_feed_d)
  );

  matmul_skew_feeder #(
    .DATA_WIDTH(DATA_WIDTH), .MAX_DIM(MAX_DIM), .TRANSPOSE(1'b1)
  ) u_feed_b (
    .active_i(state_d == S_FEED),
    .t_i     (t_d),
    .lanes_i (m_d),
    .k_i     (k_d),
    .flat_i  (mat_b_i),
    .feed_o  (b_feed_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      lat_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      m_q      <= '0;
      a_feed_q <= '0;
      b_feed_q <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      lat_q    <= lat_d;
      n_q      <= n_d;
      k_q      <= k_d;
      m_q      <= m_d;
      a_feed_q <= a_feed_d;
      b_feed_q <= b_feed_d;
    end
  end

  assign a_feed_o   = a_feed_q;
  assign b_feed_o   = b_feed_q;
  assign pe_clear_o = (state_q == S_CLEAR);
  assign pe_valid_o = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign sp_wr_o    = (state_q == S_WRITE);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed self-checking bench for matmul_sequencer (4x4 array, 16-bit, PE_LAT=1).
module tb_matmul_sequencer;

  logic         clk = 1'b0;
  logic         rst, start_i, sp_ack_i;
  logic [1:0]   dim_n_i, dim_k_i, dim_m_i;
  logic [255:0] mat_a_i, mat_b_i;
  logic [63:0]  a_feed_o, b_feed_o;
  logic         pe_clear_o, pe_valid_o, sp_wr_o, busy_o, done_o;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int pv, dn, dcyc, d1, d2, clr2, spw;

  always #5 clk = ~clk;

  matmul_sequencer #(.DATA_WIDTH(16), .MAX_DIM(4), .PE_LAT(1)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .dim_n_i(dim_n_i), .dim_k_i(dim_k_i), .dim_m_i(dim_m_i),
    .mat_a_i(mat_a_i), .mat_b_i(mat_b_i),
    .a_feed_o(a_feed_o), .b_feed_o(b_feed_o),
    .pe_clear_o(pe_clear_o), .pe_valid_o(pe_valid_o),
    .sp_wr_o(sp_wr_o), .sp_ack_i(sp_ack_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive start in "cycle 0" so that the following edge is edge 0.
  task automatic go(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m, input bit hold);
    dim_n_i = n; dim_k_i = k; dim_m_i = m;
    start_i = 1'b1;
    cyc = 0;
    tick();
    if (!hold) start_i = 1'b0;
  endtask

  task automatic load_seq_ident();
    mat_a_i = '0; mat_b_i = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mat_a_i[(r*4+c)*16 +: 16] = 16'(r*4 + c + 1);
        if (r == c) mat_b_i[(r*4+c)*16 +: 16] = 16'd1;
      end
  endtask

  task automatic load_scalar();
    mat_a_i = '0; mat_b_i = '0;
    mat_a_i[15:0] = 16'hFFFD;
    mat_b_i[15:0] = 16'd7;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; sp_ack_i = 1'b0;
    dim_n_i = '0; dim_k_i = '0; dim_m_i = '0;
    mat_a_i = '0; mat_b_i = '0;
    cyc = 0;
    tick(); tick();
    chk("reset_a", a_feed_o, 64'h0);
    chk("reset_b", b_feed_o, 64'h0);
    chk("reset_ctl", 64'({pe_clear_o, pe_valid_o, sp_wr_o, busy_o, done_o}), 64'h0);
    rst = 1'b0;
    tick();

    // 4x4x4, A sequential, B identity, ack always present
    load_seq_ident();
    sp_ack_i = 1'b1;
    go(2'd3, 2'd3, 2'd3, 1'b0);
    pv = 0; dn = 0; dcyc = 0;
    repeat (16) begin
      if (cyc == 1) chk("t1_clear", 64'({pe_clear_o, busy_o}), 64'h3);
      if (cyc == 2) begin
        chk("t1_a_t0", a_feed_o, 64'h0000_0000_0000_0001);
        chk("t1_b_t0", b_feed_o, 64'h0000_0000_0000_0001);
      end
      if (cyc == 3) begin
        chk("t1_a_t1", a_feed_o, 64'h0000_0000_0005_0002);
        chk("t1_b_t1", b_feed_o, 64'h0000_0000_0000_0000);
      end
      if (cyc == 4) begin
        chk("t1_a_t2", a_feed_o, 64'h0000_0009_0006_0003);
        chk("t1_b_t2", b_feed_o, 64'h0000_0000_0001_0000);
      end
      if (cyc == 8) begin
        chk("t1_a_t6", a_feed_o, 64'h0010_0000_0000_0000);
        chk("t1_b_t6", b_feed_o, 64'h0001_0000_0000_0000);
      end
      if (cyc == 13) chk("t1_wr", 64'(sp_wr_o), 64'h1);
      if (pe_valid_o) pv++;
      if (done_o) begin dn++; dcyc = cyc; end
      tick();
    end
    chk("t1_valid_cnt", 64'(pv), 64'd11);
    chk("t1_done_cnt", 64'(dn), 64'd1);
    chk("t1_done_cyc", 64'(dcyc), 64'd14);
    chk("t1_idle", 64'(busy_o), 64'h0);

    // 1x1x1, signed operand
    load_scalar();
    go(2'd0, 2'd0, 2'd0, 1'b0);
    pv = 0; dcyc = 0;
    repeat (8) begin
      if (cyc == 2) begin
        chk("t2_a", a_feed_o, 64'h0000_0000_0000_FFFD);
        chk("t2_b", b_feed_o, 64'h0000_0000_0000_0007);
      end
      if (cyc == 3) chk("t2_drain_a", a_feed_o, 64'h0);
      if (pe_valid_o) pv++;
      if (done_o) dcyc = cyc;
      tick();
    end
    chk("t2_valid_cnt", 64'(pv), 64'd2);
    chk("t2_done_cyc", 64'(dcyc), 64'd5);

    // 2x3x1, all operand elements nonzero
    for (int i = 0; i < 16; i++) begin
      mat_a_i[i*16 +: 16] = 16'(100 + i);
      mat_b_i[i*16 +: 16] = 16'(200 + i);
    end
    go(2'd1, 2'd2, 2'd0, 1'b0);
    pv = 0; dcyc = 0;
    repeat (10) begin
      chk("t3_a_hi_zero", 64'(a_feed_o[63:32]), 64'h0);
      chk("t3_b_hi_zero", 64'(b_feed_o[63:16]), 64'h0);
      if (cyc == 4) begin
        chk("t3_a_t2", a_feed_o, 64'h0000_0000_0069_0066);
        chk("t3_b_t2", b_feed_o, 64'h0000_0000_0000_00D0);
      end
      if (cyc == 5) chk("t3_a_t3", a_feed_o, 64'h0000_0000_006A_0000);
      if (pe_valid_o) pv++;
      if (done_o) dcyc = cyc;
      tick();
    end
    chk("t3_valid_cnt", 64'(pv), 64'd5);
    chk("t3_done_cyc", 64'(dcyc), 64'd8);

    // Ack pulsed in FEED (ignored), then withheld 5 WRITE cycles
    load_scalar();
    sp_ack_i = 1'b0;
    go(2'd0, 2'd0, 2'd0, 1'b0);
    spw = 0; dn = 0; dcyc = 0;
    repeat (12) begin
      sp_ack_i = (cyc == 2) || (cyc == 9);
      if (cyc == 3) chk("t4_no_wr_drain", 64'(sp_wr_o), 64'h0);
      if (cyc == 4) chk("t4_wr_first", 64'(sp_wr_o), 64'h1);
      if (sp_wr_o) spw++;
      if (done_o) begin dn++; dcyc = cyc; end
      tick();
    end
    sp_ack_i = 1'b0;
    chk("t4_wr_cnt", 64'(spw), 64'd6);
    chk("t4_done_cnt", 64'(dn), 64'd1);
    chk("t4_done_cyc", 64'(dcyc), 64'd10);

    // start held high; dims change mid-run
    sp_ack_i = 1'b1;
    go(2'd0, 2'd0, 2'd0, 1'b1);
    dn = 0; d1 = 0; d2 = 0; clr2 = 0;
    repeat (22) begin
      if (cyc == 2) begin dim_n_i = 2'd3; dim_k_i = 2'd3; dim_m_i = 2'd3; end
      if (cyc == 8) start_i = 1'b0;
      if (cyc == 6) chk("t5_gap_idle", 64'(busy_o), 64'h0);
      if (pe_clear_o && cyc > 1) clr2 = cyc;
      if (done_o) begin
        dn++;
        if (dn == 1) d1 = cyc; else d2 = cyc;
      end
      tick();
    end
    chk("t5_done_cnt", 64'(dn), 64'd2);
    chk("t5_done1_cyc", 64'(d1), 64'd5);
    chk("t5_clear2_cyc", 64'(clr2), 64'd7);
    chk("t5_done2_cyc", 64'(d2), 64'd20);
    chk("t5_end_idle", 64'(busy_o), 64'h0);

    // Reset during FEED at t=3
    load_seq_ident();
    go(2'd3, 2'd3, 2'd3, 1'b0);
    repeat (4) tick();
    chk("t6_a_t3", a_feed_o, 64'h000D_000A_0007_0004);
    rst = 1'b1;
    tick();
    chk("t6_rst_a", a_feed_o, 64'h0);
    chk("t6_rst_b", b_feed_o, 64'h0);
    chk("t6_rst_ctl", 64'({pe_clear_o, pe_valid_o, sp_wr_o, busy_o, done_o}), 64'h0);
    rst = 1'b0;
    go(2'd3, 2'd3, 2'd3, 1'b0);
    pv = 0; dcyc = 0;
    repeat (16) begin
      if (cyc == 1) chk("t6_clear", 64'(pe_clear_o), 64'h1);
      if (cyc == 2) chk("t6_a_t0", a_feed_o, 64'h0000_0000_0000_0001);
      if (pe_valid_o) pv++;
      if (done_o) dcyc = cyc;
      tick();
    end
    chk("t6_valid_cnt", 64'(pv), 64'd11);
    chk("t6_done_cyc", 64'(dcyc), 64'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
